// File: rtl/mac_scandoubler.sv
// mac_scandoubler: line-doubling scan converter; each input line is buffered in one
// bank of a ping-pong line buffer while the other bank is replayed twice at ce_2x.
module mac_scandoubler #(
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce_pix,
  input  logic ce_2x,
  input  logic pixel_in,
  input  logic video_en_in,
  input  logic hsync_in,
  input  logic vsync_in,
  input  logic hblank_n_in,
  input  logic vblank_n_in,
  output logic ce_out,
  output logic pixel_out,
  output logic hsync_out,
  output logic vsync_out,
  output logic hblank_n_out,
  output logic vblank_n_out,
  output logic de_out
);
  localparam logic [ADDR_W-1:0] MAX = '1;
  logic [2:0] mem [0:(2**(ADDR_W+1))-1];
  logic hs_q, bank_q, seen_q, half_q, half_d, hs_rise, wrap;
  logic vs_line_q, vb_line_q, v1_q, hs1_q, vs1_q, vb1_q, hbn;
  logic [ADDR_W-1:0] wptr_q, wptr_d, hs_len_q, hs_len_d, line_len_q, hs_width_q, rptr_q, rptr_d;
  logic [ADDR_W:0] wr_addr;
  logic [2:0] rd_q;
  always_comb begin
    hs_rise  = ce_pix & hsync_in & ~hs_q;
    wr_addr  = hs_rise ? {~bank_q, {ADDR_W{1'b0}}} : {bank_q, wptr_q};
    wptr_d   = !ce_pix ? wptr_q : hs_rise ? ADDR_W'(1) : (wptr_q == MAX) ? wptr_q : wptr_q + 1'b1;
    hs_len_d = !ce_pix ? hs_len_q : hs_rise ? ADDR_W'(1) :
               (hsync_in && hs_len_q != MAX) ? hs_len_q + 1'b1 : hs_len_q;
    wrap     = ce_2x && line_len_q != '0 && rptr_q == line_len_q - 1'b1;
    rptr_d   = (hs_rise || line_len_q == '0 || wrap) ? '0 : ce_2x ? rptr_q + 1'b1 : rptr_q;
    half_d   = hs_rise ? 1'b0 : half_q ^ wrap;
    hbn      = v1_q & rd_q[0] & vb1_q;
  end
  // Buffer contents are deliberately not reset; line_len == 0 masks them.
  always_ff @(posedge clk) begin
    if (ce_pix) mem[wr_addr] <= {pixel_in, video_en_in, hblank_n_in};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      bank_q <= 1'b0;
      seen_q <= 1'b0;
      half_q <= 1'b0;
      wptr_q <= '0;
      hs_len_q <= '0;
      line_len_q <= '0;
      hs_width_q <= '0;
      rptr_q <= '0;
      vs_line_q <= 1'b0;
      vb_line_q <= 1'b0;
      rd_q <= '0;
      v1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      vb1_q <= 1'b0;
      ce_out <= 1'b0;
      pixel_out <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      hblank_n_out <= 1'b0;
      vblank_n_out <= 1'b0;
      de_out <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      hs_len_q <= hs_len_d;
      rptr_q <= rptr_d;
      half_q <= half_d;
      ce_out <= ce_2x;
      if (ce_pix) hs_q <= hsync_in;
      // The first edge after reset only starts a line; the partial line before it is dropped.
      if (hs_rise) begin
        line_len_q <= seen_q ? wptr_q : '0;
        seen_q <= 1'b1;
        hs_width_q <= hs_len_q;
        vs_line_q <= vsync_in;
        vb_line_q <= vblank_n_in;
        bank_q <= ~bank_q;
      end
      if (ce_2x) begin
        rd_q <= mem[{~bank_q, rptr_q}];
        v1_q <= line_len_q != '0;
        hs1_q <= rptr_q < hs_width_q;
        vs1_q <= vs_line_q;
        vb1_q <= vb_line_q;
        pixel_out <= v1_q & rd_q[2];
        hsync_out <= v1_q & hs1_q;
        vsync_out <= v1_q & vs1_q;
        hblank_n_out <= hbn;
        vblank_n_out <= v1_q & vb1_q;
        de_out <= rd_q[1] & hbn;
      end
    end
  end
endmodule

// File: tb/tb_mac_scandoubler.sv
// tb_mac_scandoubler: scoreboard bench; a line-level reference model queues the expected
// output word for every ce_2x tick and a negedge monitor compares the DUT against it.
module tb_mac_scandoubler;
  localparam int AW = 10;
  localparam int N = 1 << AW;
  logic clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0, ce_2x = 1'b0;
  logic pixel_in = 1'b0, video_en_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic hblank_n_in = 1'b0, vblank_n_in = 1'b0;
  logic ce_out, pixel_out, hsync_out, vsync_out, hblank_n_out, vblank_n_out, de_out;
  logic [5:0] sbq [$];
  logic [5:0] got, exp_w;
  bit [2:0] wr_buf [N];
  bit [2:0] rd_buf [N];
  int m_wptr, m_hslen, m_L, m_W, m_rptr;
  bit m_vs, m_vb, m_prev_hs, m_seen;
  int n_checks = 0, n_fail = 0;
  int hs_cnt, vs_cnt, de_cnt;
  bit mon_en = 1'b0, chk_swap = 1'b0;

  mac_scandoubler #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .ce_2x(ce_2x), .pixel_in(pixel_in),
    .video_en_in(video_en_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblank_n_in(hblank_n_in), .vblank_n_in(vblank_n_in), .ce_out(ce_out),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblank_n_out(hblank_n_out), .vblank_n_out(vblank_n_out), .de_out(de_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && ce_out) begin
      got = {pixel_out, hsync_out, vsync_out, hblank_n_out, vblank_n_out, de_out};
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: output %b with nothing expected at %0t", got, $time);
      end else begin
        exp_w = sbq.pop_front();
        if (got !== exp_w) begin
          n_fail++;
          $display("FAIL sb_out {pix,hs,vs,hbn,vbn,de}: got %b expected %b at %0t", got, exp_w, $time);
        end
      end
      if (hsync_out) hs_cnt++;
      if (vsync_out) vs_cnt++;
      if (de_out) de_cnt++;
    end
  end

  task automatic model_reset();
    m_wptr = 0; m_hslen = 0; m_L = 0; m_W = 0; m_rptr = 0;
    m_vs = 0; m_vb = 0; m_prev_hs = 0; m_seen = 0;
    sbq.delete();
    sbq.push_back(6'b0);
  endtask

  // Expected word for the read made at this ce_2x edge, then the edge's state changes.
  task automatic model_edge(input bit cp, input bit p, ven, hs, vs, hbn, vbn);
    bit rise, v, ho;
    bit [2:0] e;
    rise = cp && hs && !m_prev_hs;
    v = m_L != 0;
    e = rd_buf[m_rptr];
    ho = v & e[0] & m_vb;
    sbq.push_back({v & e[2], v & (m_rptr < m_W), v & m_vs, ho, v & m_vb, e[1] & ho});
    m_rptr = (rise || m_L == 0 || m_rptr == m_L - 1) ? 0 : m_rptr + 1;
    if (cp) begin
      if (rise) begin
        m_L = m_seen ? m_wptr : 0;
        m_seen = 1;
        m_W = m_hslen;
        m_vs = vs;
        m_vb = vbn;
        rd_buf = wr_buf;
        wr_buf[0] = {p, ven, hbn};
        m_wptr = 1;
        m_hslen = 1;
      end else begin
        wr_buf[m_wptr] = {p, ven, hbn};
        if (m_wptr < N - 1) m_wptr++;
        if (hs && m_hslen < N - 1) m_hslen++;
      end
      m_prev_hs = hs;
    end
  endtask

  // One input pixel: four clocks, ce_pix on the first, ce_2x on the first and third.
  task automatic sample(input bit p, ven, hs, vs, hbn, vbn);
    bit r;
    r = hs && !m_prev_hs;
    pixel_in = p; video_en_in = ven; hsync_in = hs; vsync_in = vs;
    hblank_n_in = hbn; vblank_n_in = vbn;
    for (int k = 0; k < 4; k++) begin
      ce_pix = (k == 0);
      ce_2x = (k % 2 == 0);
      if (k == 0 && r && chk_swap) begin
        n_checks++;
        if (dut.half_q !== 1'b1) begin
          n_fail++;
          $display("FAIL half_before_swap: got %b expected 1", dut.half_q);
        end
      end
      @(posedge clk);
      if (ce_2x) model_edge(k == 0, p, ven, hs, vs, hbn, vbn);
      #1;
      if (k == 0 && r && chk_swap) begin
        n_checks++;
        if (dut.rptr_q !== '0 || dut.half_q !== 1'b0) begin
          n_fail++;
          $display("FAIL swap_wrap: rptr=%0d half=%b expected rptr=0 half=0", dut.rptr_q, dut.half_q);
        end
      end
    end
  endtask

  // Samples [first, n) of an n-pixel line; mode 0 = alternating, 1 = random, 2 = overlong marker.
  task automatic line(input int first, n, hsw, input bit vs, vbn, input int mode);
    bit p, hbn;
    for (int i = first; i < n; i++) begin
      hbn = (i >= hsw + 4) && (i < n - 4);
      p = (mode == 0) ? (i % 2 == 0) : (mode == 1) ? bit'($urandom_range(1)) :
          (i == 0 || i == n - 1) ? 1'b1 : (i >= N - 1) ? 1'b0 : (i % 3 == 0);
      sample(p, hbn && (i < n - 8), i < hsw, vs, hbn, vbn);
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    ce_pix = 0; ce_2x = 0;
    #3 reset_n = 0;
    #1;
    n_checks++;
    if ({ce_out, pixel_out, hsync_out, vsync_out, hblank_n_out, vblank_n_out, de_out} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {ce_out, pixel_out, hsync_out, vsync_out, hblank_n_out, vblank_n_out, de_out});
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (dut.line_len_q !== '0 || dut.wptr_q !== '0 || dut.rptr_q !== '0) begin
      n_fail++;
      $display("FAIL reset_state: line_len=%0d wptr=%0d rptr=%0d expected 0", dut.line_len_q, dut.wptr_q, dut.rptr_q);
    end
    model_reset();
    #1 reset_n = 1;
    mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic_lines();
    line(0, 704, 68, 0, 1, 0);
    line(0, 704, 68, 0, 1, 0);
    hs_cnt = 0;
    line(0, 704, 68, 0, 1, 0);
    n_checks++;
    if (dut.line_len_q !== 704) begin
      n_fail++;
      $display("FAIL line_len: got %0d expected 704", dut.line_len_q);
    end
    n_checks++;
    if (dut.hs_width_q !== 68) begin
      n_fail++;
      $display("FAIL hs_width: got %0d expected 68", dut.hs_width_q);
    end
    n_checks++;
    if (hs_cnt !== 136) begin
      n_fail++;
      $display("FAIL hsync_out_ticks: got %0d expected 136", hs_cnt);
    end
  endtask

  task automatic test_vsync();
    vs_cnt = 0;
    for (int l = 0; l < 6; l++) line(0, 40, 4, l == 2 || l == 3, 1, 1);
    n_checks++;
    if (vs_cnt !== 160) begin
      n_fail++;
      $display("FAIL vsync_out_ticks: got %0d expected 160", vs_cnt);
    end
  endtask

  task automatic test_overlong();
    line(0, 1100, 68, 0, 1, 2);
    n_checks++;
    if (dut.wptr_q !== N - 1) begin
      n_fail++;
      $display("FAIL wptr_saturate: got %0d expected %0d", dut.wptr_q, N - 1);
    end
    line(0, 704, 68, 0, 1, 1);
    n_checks++;
    if (dut.line_len_q !== N - 1) begin
      n_fail++;
      $display("FAIL line_len_saturate: got %0d expected %0d", dut.line_len_q, N - 1);
    end
    line(0, 704, 68, 0, 1, 1);
  endtask

  task automatic test_reset_midline();
    line(0, 300, 68, 0, 1, 1);
    do_reset();
    de_cnt = 0;
    line(300, 704, 68, 0, 1, 1);
    line(0, 704, 68, 0, 1, 1);
    n_checks++;
    if (de_cnt !== 0) begin
      n_fail++;
      $display("FAIL de_before_second_edge: got %0d expected 0", de_cnt);
    end
    line(0, 704, 68, 0, 1, 0);
    n_checks++;
    if (de_cnt !== 1248) begin
      n_fail++;
      $display("FAIL de_after_second_edge: got %0d expected 1248", de_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < 3; l++) line(0, 50, 6, 0, l != 1, 1);
    chk_swap = 1;
    line(0, 50, 6, 0, 1, 1);
    chk_swap = 0;
    line(0, 50, 6, 0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_basic_lines();
    test_vsync();
    test_overlong();
    test_reset_midline();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_scandoubler.md
MAC_SCANDOUBLER -- requirements
Module: mac_scandoubler

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, which sets the line-buffer address width; the maximum input line length is 2^ADDR_W-1 ce_pix cycles.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ce_pix, input, 1 bit: input pixel-rate enable, the same enable that drives the video generator.
REQ-005 SHALL have port ce_2x, input, 1 bit: output enable at twice the ce_pix rate; every ce_pix cycle is also a ce_2x cycle.
REQ-006 SHALL have port pixel_in, input, 1 bit: pixel from the video generator; 1 = white.
REQ-007 SHALL have port video_en_in, input, 1 bit: the generator's paper/valid flag.
REQ-008 SHALL have ports hsync_in and vsync_in, input, 1 bit each: active-high syncs.
REQ-009 SHALL have ports hblank_n_in and vblank_n_in, input, 1 bit each: active-low blanks.
REQ-010 SHALL have port ce_out, output, 1 bit: equals ce_2x, registered, aligned with the outputs.
REQ-011 SHALL have ports pixel_out, hsync_out, vsync_out, output, 1 bit each: doubled-rate video and syncs.
REQ-012 SHALL have ports hblank_n_out, vblank_n_out, de_out, output, 1 bit each: doubled-rate blanks and display enable.

Function
REQ-013 SHALL keep two line-buffer banks of 2^ADDR_W x 3 bits each, storing {pixel_in, video_en_in, hblank_n_in}; one bank is written while the other is read.
REQ-014 SHALL detect a hsync_in rising edge by comparing hsync_in against its value on the previous ce_pix cycle; detection happens only on ce_pix cycles.
REQ-015 On each ce_pix cycle, SHALL write the current sample to the write bank at address wptr, then increment wptr.
REQ-016 SHALL saturate wptr at 2^ADDR_W-1: later samples overwrite that last location, and no wrap occurs.
REQ-017 While hsync_in is high, SHALL count ce_pix cycles into hs_len (saturating).
REQ-018 On a hsync_in rising edge, SHALL, in the same cycle: latch line_len <= wptr; latch hs_width <= hs_len; latch vs_line <= vsync_in; latch vb_line <= vblank_n_in; swap the banks; clear wptr to 0; restart hs_len at 1. The sample taken in that cycle is written at address 0 of the new bank.
REQ-019 On each ce_2x cycle, SHALL increment rptr, wrapping it to 0 when rptr == line_len-1.
REQ-020 SHALL maintain a half flag that toggles on each rptr wrap, so that each input line produces exactly two output lines.
REQ-021 On a bank swap, SHALL reset rptr to 0 and half to 0, overriding any wrap in the same cycle.
REQ-022 SHALL read the read bank at rptr with a synchronous read (1 clk); the outputs SHALL be registered on the next ce_2x cycle. Total pipeline latency from rptr to the outputs is 2 ce_2x cycles, and hsync_out/vsync_out SHALL be delayed equally.
REQ-023 SHALL drive hsync_out = 1 while the delayed rptr < hs_width.
REQ-024 SHALL drive vsync_out = vs_line and vblank_n_out = vb_line, both constant across the two output lines of an input line.
REQ-025 SHALL drive pixel_out = stored pixel, and hblank_n_out = stored hblank_n AND vb_line.
REQ-026 SHALL drive de_out = stored video_en AND hblank_n_out.
REQ-027 While line_len == 0 (no complete line measured yet), SHALL hold rptr at 0 and force pixel_out = 0, de_out = 0, hsync_out = 0, blanks asserted (the _n outputs = 0), and vsync_out = 0.
REQ-028 When ce_pix is low, SHALL perform no write and leave wptr, hs_len and the hsync edge register unchanged.
REQ-029 When ce_2x is low, SHALL hold rptr and all outputs.
REQ-030 SHALL read from the bank not being written, so a simultaneous read and write never target the same bank.

Reset
REQ-031 While reset_n = 0, SHALL asynchronously clear: wptr, rptr, hs_len, line_len, hs_width, half, the bank select, and the hsync edge register.
REQ-032 While reset_n = 0, SHALL asynchronously set: vs_line = 0, vb_line = 0, and all outputs = 0 (ce_out = 0).
REQ-033 SHALL NOT reset the buffer contents; REQ-027 masks them until a full line is measured.
REQ-034 A reset asserted mid-line SHALL discard the partial line, and output SHALL resume only after two hsync_in rising edges.

Verification
REQ-035 Reset, then 3 input lines of 704 ce_pix with hsync high for 68 ce_pix -> line_len = 704, hs_width = 68, and 2 output lines per input line, each 704 ce_2x with hsync_out high for 68 ce_2x.
REQ-036 Pixel pattern alternating 1,0 per ce_pix on line N -> both output lines N pixel_out at rptr 0..703 = 1,0,1,0..., appearing 2 ce_2x after rptr.
REQ-037 vsync_in high on lines 365-369 -> vsync_out high for exactly 10 output lines, with no partial-line change.
REQ-038 Input line of 1100 ce_pix (ADDR_W = 10) -> wptr saturates at 1023, line_len = 1023, and no write wraps to address 0.
REQ-039 reset_n pulsed low at mid-line -> all outputs 0 immediately; de_out stays 0 until the second following hsync_in rising edge.
REQ-040 Bank swap coinciding with an rptr wrap -> rptr = 0 and half = 0 after the swap, with no glitch on hsync_out.
